// File: rtl/algo_3ror1w_cmd_sched.sv
// Command scheduler for a memory core that does either three reads or one write per cycle.
// Client writes are buffered in an in-order FIFO and drained when reads are idle, starved, or hazarded.
module algo_3ror1w_cmd_sched #(
   parameter int WIDTH      = 32,
   parameter int BITADDR    = 13,
   parameter int WFDEPTH    = 4,
   parameter int BITWFIFO   = 2,
   parameter int STARVE_MAX = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ready,
   input  logic [2:0]             cl_read,
   input  logic [3*BITADDR-1:0]   cl_rd_adr,
   output logic                   cl_rd_rdy,
   input  logic                   cl_write,
   input  logic [BITADDR-1:0]     cl_wr_adr,
   input  logic [WIDTH-1:0]       cl_din,
   output logic                   cl_wr_rdy,
   output logic [2:0]             read,
   output logic [3*BITADDR-1:0]   rd_adr,
   output logic                   write,
   output logic [BITADDR-1:0]     wr_adr,
   output logic [WIDTH-1:0]       din,
   output logic [BITWFIFO:0]      wf_cnt
);

   localparam logic [BITWFIFO:0] FULL_CNT   = (BITWFIFO+1)'(WFDEPTH);
   localparam logic [7:0]        STARVE_LIM = 8'(STARVE_MAX);

   typedef enum logic [1:0] {
      MODE_IDLE,
      MODE_READ,
      MODE_WRITE
   } mode_t;

   mode_t                 mode;
   logic [BITADDR-1:0]    fifo_adr [WFDEPTH];
   logic [WIDTH-1:0]      fifo_dat [WFDEPTH];
   logic [BITWFIFO-1:0]   wptr;
   logic [BITWFIFO-1:0]   rptr;
   logic [BITWFIFO-1:0]   ent_off;
   logic [7:0]            starve_cnt;
   logic                  hazard;
   logic                  force_wr;
   logic                  push;
   logic                  pop;

   assign cl_wr_rdy = (wf_cnt != FULL_CNT);
   assign push      = cl_write && cl_wr_rdy;

   // An entry is valid when its distance from the read pointer is below the count.
   always_comb begin
      hazard  = 1'b0;
      ent_off = '0;
      for (int e = 0; e < WFDEPTH; e++) begin
         ent_off = BITWFIFO'(e) - rptr;
         if ({1'b0, ent_off} < wf_cnt) begin
            for (int p = 0; p < 3; p++) begin
               if (cl_read[p] && (cl_rd_adr[p*BITADDR +: BITADDR] == fifo_adr[e]))
                  hazard = 1'b1;
            end
         end
      end
   end

   assign force_wr  = (wf_cnt != '0) &&
                      ((wf_cnt == FULL_CNT) || (starve_cnt == STARVE_LIM) || hazard);
   assign cl_rd_rdy = ready && !force_wr;

   // READ and WRITE conditions are mutually exclusive: READ needs !force_wr and a request.
   always_comb begin
      mode = MODE_IDLE;
      if (ready && cl_rd_rdy && (cl_read != 3'b000))
         mode = MODE_READ;
      else if (ready && (wf_cnt != '0) && (force_wr || (cl_read == 3'b000)))
         mode = MODE_WRITE;
   end

   assign pop = (mode == MODE_WRITE);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_adr[wptr] <= cl_wr_adr;
         fifo_dat[wptr] <= cl_din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read       <= '0;
         write      <= 1'b0;
         rd_adr     <= '0;
         wr_adr     <= '0;
         din        <= '0;
         wf_cnt     <= '0;
         wptr       <= '0;
         rptr       <= '0;
         starve_cnt <= '0;
      end else begin
         case (mode)
            MODE_READ: begin
               read   <= cl_read;
               rd_adr <= cl_rd_adr;
               write  <= 1'b0;
            end
            MODE_WRITE: begin
               read   <= '0;
               write  <= 1'b1;
               wr_adr <= fifo_adr[rptr];
               din    <= fifo_dat[rptr];
            end
            default: begin
               read  <= '0;
               write <= 1'b0;
            end
         endcase

         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;

         case ({push, pop})
            2'b10:   wf_cnt <= wf_cnt + 1'b1;
            2'b01:   wf_cnt <= wf_cnt - 1'b1;
            default: wf_cnt <= wf_cnt;
         endcase

         if (pop || (wf_cnt == '0))
            starve_cnt <= '0;
         else if ((mode == MODE_READ) && (starve_cnt != STARVE_LIM))
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_algo_3ror1w_cmd_sched.sv
// Directed bench for algo_3ror1w_cmd_sched: reads, writes, starvation, hazards, full FIFO, reset.
module tb_algo_3ror1w_cmd_sched;

   localparam int WIDTH    = 32;
   localparam int BITADDR  = 13;
   localparam int BITWFIFO = 2;

   logic                  clk;
   logic                  rst;
   logic                  ready;
   logic [2:0]            cl_read;
   logic [3*BITADDR-1:0]  cl_rd_adr;
   logic                  cl_rd_rdy;
   logic                  cl_write;
   logic [BITADDR-1:0]    cl_wr_adr;
   logic [WIDTH-1:0]      cl_din;
   logic                  cl_wr_rdy;
   logic [2:0]            read;
   logic [3*BITADDR-1:0]  rd_adr;
   logic                  write;
   logic [BITADDR-1:0]    wr_adr;
   logic [WIDTH-1:0]      din;
   logic [BITWFIFO:0]     wf_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   algo_3ror1w_cmd_sched dut (
      .clk       (clk),
      .rst       (rst),
      .ready     (ready),
      .cl_read   (cl_read),
      .cl_rd_adr (cl_rd_adr),
      .cl_rd_rdy (cl_rd_rdy),
      .cl_write  (cl_write),
      .cl_wr_adr (cl_wr_adr),
      .cl_din    (cl_din),
      .cl_wr_rdy (cl_wr_rdy),
      .read      (read),
      .rd_adr    (rd_adr),
      .write     (write),
      .wr_adr    (wr_adr),
      .din       (din),
      .wf_cnt    (wf_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3*BITADDR-1:0] radr(input logic [BITADDR-1:0] a0,
                                                 input logic [BITADDR-1:0] a1,
                                                 input logic [BITADDR-1:0] a2);
      return {a2, a1, a0};
   endfunction

   initial begin
      rst       = 1'b1;
      ready     = 1'b0;
      cl_read   = 3'b000;
      cl_rd_adr = '0;
      cl_write  = 1'b0;
      cl_wr_adr = '0;
      cl_din    = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_read", 64'(read), 64'h0);
      chk("rst_write", 64'(write), 64'h0);
      chk("rst_wf_cnt", 64'(wf_cnt), 64'h0);
      chk("rst_rd_adr", 64'(rd_adr), 64'h0);
      chk("rst_wr_adr", 64'(wr_adr), 64'h0);
      chk("rst_din", 64'(din), 64'h0);
      rst = 1'b0;
      step();

      // Reads only
      ready     = 1'b1;
      cl_read   = 3'b101;
      cl_rd_adr = radr(13'h10, 13'h0, 13'h20);
      #1;
      chk("rd_only_rdy", 64'(cl_rd_rdy), 64'h1);
      step();
      chk("rd_only_read", 64'(read), 64'h5);
      chk("rd_only_adr", 64'(rd_adr), 64'(radr(13'h10, 13'h0, 13'h20)));
      chk("rd_only_write", 64'(write), 64'h0);
      cl_read = 3'b000;
      step();
      chk("idle_read", 64'(read), 64'h0);
      chk("idle_adr_hold", 64'(rd_adr), 64'(radr(13'h10, 13'h0, 13'h20)));

      // Single write with no reads
      cl_write  = 1'b1;
      cl_wr_adr = 13'h5;
      cl_din    = 32'hAA;
      #1;
      chk("wr_rdy_empty", 64'(cl_wr_rdy), 64'h1);
      step();
      chk("wr_cnt_1", 64'(wf_cnt), 64'h1);
      chk("wr_not_yet", 64'(write), 64'h0);
      cl_write = 1'b0;
      step();
      chk("wr_strobe", 64'(write), 64'h1);
      chk("wr_adr", 64'(wr_adr), 64'h5);
      chk("wr_din", 64'(din), 64'hAA);
      chk("wr_cnt_0", 64'(wf_cnt), 64'h0);
      chk("wr_no_read", 64'(read), 64'h0);
      step();
      chk("wr_done", 64'(write), 64'h0);
      chk("wr_adr_hold", 64'(wr_adr), 64'h5);

      // Starvation: write queued with ready low, then continuous triple reads
      ready     = 1'b0;
      cl_write  = 1'b1;
      cl_wr_adr = 13'h33;
      cl_din    = 32'h1234;
      step();
      chk("stv_cnt", 64'(wf_cnt), 64'h1);
      chk("stv_no_issue", 64'(write), 64'h0);
      cl_write  = 1'b0;
      ready     = 1'b1;
      cl_read   = 3'b111;
      cl_rd_adr = radr(13'h1, 13'h2, 13'h3);
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("stv_rdy_%0d", i), 64'(cl_rd_rdy), 64'h1);
         step();
         chk($sformatf("stv_read_%0d", i), 64'(read), 64'h7);
         chk($sformatf("stv_nowr_%0d", i), 64'(write), 64'h0);
      end
      #1;
      chk("stv_forced_rdy", 64'(cl_rd_rdy), 64'h0);
      step();
      chk("stv_write", 64'(write), 64'h1);
      chk("stv_wr_adr", 64'(wr_adr), 64'h33);
      chk("stv_din", 64'(din), 64'h1234);
      chk("stv_read_off", 64'(read), 64'h0);
      #1;
      chk("stv_resume_rdy", 64'(cl_rd_rdy), 64'h1);
      step();
      chk("stv_resume_read", 64'(read), 64'h7);
      cl_read = 3'b000;
      step();

      // Hazard: read to an address queued in the FIFO
      cl_write  = 1'b1;
      cl_wr_adr = 13'h40;
      cl_din    = 32'h77;
      step();
      chk("hz_cnt", 64'(wf_cnt), 64'h1);
      cl_write  = 1'b0;
      cl_read   = 3'b010;
      cl_rd_adr = radr(13'h0, 13'h40, 13'h0);
      #1;
      chk("hz_rdy_low", 64'(cl_rd_rdy), 64'h0);
      step();
      chk("hz_write", 64'(write), 64'h1);
      chk("hz_wr_adr", 64'(wr_adr), 64'h40);
      chk("hz_read_off", 64'(read), 64'h0);
      #1;
      chk("hz_rdy_back", 64'(cl_rd_rdy), 64'h1);
      step();
      chk("hz_read", 64'(read), 64'h2);
      chk("hz_rd_adr", 64'(rd_adr), 64'(radr(13'h0, 13'h40, 13'h0)));
      cl_read = 3'b000;

      // Same-cycle push does not hazard; it does from the next cycle
      ready     = 1'b0;
      cl_write  = 1'b1;
      cl_wr_adr = 13'h60;
      cl_din    = 32'h66;
      step();
      ready     = 1'b1;
      cl_wr_adr = 13'h50;
      cl_din    = 32'h55;
      cl_read   = 3'b001;
      cl_rd_adr = radr(13'h50, 13'h0, 13'h0);
      #1;
      chk("hz_same_cyc_rdy", 64'(cl_rd_rdy), 64'h1);
      step();
      chk("hz_same_cyc_read", 64'(read), 64'h1);
      chk("hz_same_cyc_cnt", 64'(wf_cnt), 64'h2);
      cl_write = 1'b0;
      #1;
      chk("hz_next_cyc_rdy", 64'(cl_rd_rdy), 64'h0);
      step();
      chk("hz_drain0_adr", 64'(wr_adr), 64'h60);
      chk("hz_drain0_din", 64'(din), 64'h66);
      #1;
      chk("hz_still_rdy", 64'(cl_rd_rdy), 64'h0);
      step();
      chk("hz_drain1_adr", 64'(wr_adr), 64'h50);
      chk("hz_drain1_din", 64'(din), 64'h55);
      chk("hz_drain_cnt", 64'(wf_cnt), 64'h0);
      #1;
      chk("hz_clear_rdy", 64'(cl_rd_rdy), 64'h1);
      cl_read = 3'b000;
      step();

      // Full FIFO with ready low, then drain in order
      ready   = 1'b0;
      cl_read = 3'b001;
      for (int i = 0; i < 5; i++) begin
         cl_write  = 1'b1;
         cl_wr_adr = 13'(13'h100 + i);
         cl_din    = 32'(32'hD0 + i);
         #1;
         chk($sformatf("full_wr_rdy_%0d", i), 64'(cl_wr_rdy), (i < 4) ? 64'h1 : 64'h0);
         chk($sformatf("full_rd_rdy_%0d", i), 64'(cl_rd_rdy), 64'h0);
         step();
         chk($sformatf("full_cnt_%0d", i), 64'(wf_cnt), (i < 4) ? 64'(i + 1) : 64'h4);
         chk($sformatf("full_noread_%0d", i), 64'(read), 64'h0);
      end
      cl_write = 1'b0;
      cl_read  = 3'b000;
      ready    = 1'b1;
      #1;
      chk("full_force_rdy", 64'(cl_rd_rdy), 64'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("drain_wr_%0d", i), 64'(write), 64'h1);
         chk($sformatf("drain_adr_%0d", i), 64'(wr_adr), 64'(13'h100 + i));
         chk($sformatf("drain_din_%0d", i), 64'(din), 64'(32'hD0 + i));
         chk($sformatf("drain_cnt_%0d", i), 64'(wf_cnt), 64'(3 - i));
      end
      step();
      chk("drain_done", 64'(write), 64'h0);

      // Reset mid-operation discards queued writes
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cl_write  = 1'b1;
         cl_wr_adr = 13'(13'h200 + i);
         cl_din    = 32'(32'hE0 + i);
         step();
      end
      cl_write = 1'b0;
      chk("rst_pre_cnt", 64'(wf_cnt), 64'h3);
      rst = 1'b1;
      #1;
      chk("rst_mid_cnt", 64'(wf_cnt), 64'h0);
      chk("rst_mid_write", 64'(write), 64'h0);
      chk("rst_mid_read", 64'(read), 64'h0);
      step();
      rst   = 1'b0;
      ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("post_rst_nowr_%0d", i), 64'(write), 64'h0);
         chk($sformatf("post_rst_cnt_%0d", i), 64'(wf_cnt), 64'h0);
      end
      cl_read   = 3'b100;
      cl_rd_adr = radr(13'h0, 13'h0, 13'h7);
      step();
      chk("post_rst_read", 64'(read), 64'h4);
      chk("post_rst_rd_adr", 64'(rd_adr), 64'(radr(13'h0, 13'h0, 13'h7)));
      cl_read = 3'b000;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/algo_3ror1w_cmd_sched.md
ALGO_3ROR1W_CMD_SCHED -- requirements
Module: algo_3ror1w_cmd_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter BITADDR, default 13, address width.
REQ-003 SHALL have parameter WFDEPTH, default 4, write-FIFO depth (power of 2, 2..16).
REQ-004 SHALL have parameter BITWFIFO, default 2, log2(WFDEPTH).
REQ-005 SHALL have parameter STARVE_MAX, default 8, maximum consecutive read-mode cycles while a write is pending (1..255).
REQ-006 SHALL have one clock and an asynchronous, active-high reset.
REQ-007 SHALL have ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- ready  in  1  memory core ready.
- cl_read  in  3  client read requests, one per port.
- cl_rd_adr  in  3*BITADDR  client read addresses, port p at [p*BITADDR +: BITADDR].
- cl_rd_rdy  out  1  reads accepted this cycle.
- cl_write  in  1  client write request.
- cl_wr_adr  in  BITADDR  client write address.
- cl_din  in  WIDTH  client write data.
- cl_wr_rdy  out  1  write accepted this cycle.
- read  out  3  memory read strobes.
- rd_adr  out  3*BITADDR  memory read addresses.
- write  out  1  memory write strobe.
- wr_adr  out  BITADDR  memory write address.
- din  out  WIDTH  memory write data.
- wf_cnt  out  BITWFIFO+1  write-FIFO occupancy.

Function
REQ-008 SHALL buffer accepted writes in an in-order FIFO of WFDEPTH entries {adr, data}.
REQ-009 SHALL drive cl_wr_rdy = (wf_cnt != WFDEPTH), combinational from registered count only; a write is accepted when cl_write && cl_wr_rdy, regardless of ready.
REQ-010 SHALL compute hazard = any port p with cl_read[p] whose cl_rd_adr equals the address of any valid FIFO entry.
REQ-011 SHALL compute force_wr = (wf_cnt != 0) && (wf_cnt == WFDEPTH || starve_cnt == STARVE_MAX || hazard).
REQ-012 SHALL drive cl_rd_rdy = ready && !force_wr, combinational.
REQ-013 SHALL select READ mode when ready && cl_rd_rdy && (cl_read != 0); reads accepted; next cycle read = cl_read, rd_adr = cl_rd_adr, write = 0.
REQ-014 SHALL select WRITE mode when ready && (wf_cnt != 0) && (force_wr || cl_read == 0); FIFO head popped; next cycle write = 1, wr_adr/din = head, read = 0.
REQ-015 SHALL otherwise select IDLE: next cycle read = 0, write = 0; address/data outputs hold previous values.
REQ-016 SHALL never assert write together with any read bit (3 reads OR 1 write per cycle).
REQ-017 SHALL give one-cycle latency from acceptance to memory strobe; all memory-side outputs registered.
REQ-018 SHALL maintain starve_cnt (8 bits): cleared on pop or when FIFO empty; incremented in READ mode with FIFO non-empty; saturates at STARVE_MAX.
REQ-019 SHALL, with ready low, issue nothing, hold cl_rd_rdy low, keep starve_cnt, and still accept writes per REQ-009.
REQ-020 SHALL, on simultaneous push and pop, update wf_cnt by net zero and keep order; push into a full FIFO is impossible by REQ-009.
REQ-021 SHALL wrap FIFO read/write pointers modulo WFDEPTH.
REQ-022 SHALL compare hazard against the entry being pushed in the same cycle only from the following cycle.

Reset
REQ-023 SHALL, on rst high, asynchronously clear read, write, rd_adr, wr_adr, din, wf_cnt, FIFO pointers, starve_cnt to 0; pending FIFO writes are discarded.
REQ-024 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Verification
REQ-025 Reads only: ready=1, cl_read=3'b101, adr0=0x10, adr2=0x20 -> next cycle read=3'b101, same addresses, write=0, cl_rd_rdy=1.
REQ-026 Write with no reads: ready=1, one write 0x5/0xAA -> wf_cnt=1, following cycle write=1, wr_adr=0x5, din=0xAA, wf_cnt=0.
REQ-027 Starvation: one write queued, cl_read=3'b111 every cycle, STARVE_MAX=8 -> 8 READ cycles, then cl_rd_rdy=0 one cycle and write issued, then reads resume.
REQ-028 Hazard: write to 0x40 queued, cl_read[1]=1 adr 0x40 -> cl_rd_rdy=0, write drained, next cycle read of 0x40 accepted.
REQ-029 Full FIFO: ready=0, 5 writes with WFDEPTH=4 -> 4 accepted, cl_wr_rdy=0 on fifth, wf_cnt=4; ready=1 -> writes drain in order.
REQ-030 Reset mid-operation: rst pulsed with wf_cnt=3 -> wf_cnt=0, write=0, read=0 immediately, no queued write later issued.
